// File: rtl/xevious_input_pkg.sv
// Shared constants for the xevious input conditioning stage: joystick bit map,
// PS/2 scan codes, held-key slots and the coin pulser state type.
package xevious_input_pkg;

  localparam int JOY_R     = 0;
  localparam int JOY_L     = 1;
  localparam int JOY_D     = 2;
  localparam int JOY_U     = 3;
  localparam int JOY_FIRE  = 4;
  localparam int JOY_BOMB  = 5;
  localparam int JOY_ST1   = 6;
  localparam int JOY_ST2   = 7;
  localparam int JOY_COIN  = 8;

  // arrows and ctrl match on the low byte only, so the extended bit is ignored
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_BOMB  = 8'h14;
  localparam logic [8:0] SC_FIRE  = 9'h029;
  localparam logic [8:0] SC_F1    = 9'h005;
  localparam logic [8:0] SC_ONE   = 9'h016;
  localparam logic [8:0] SC_F2    = 9'h006;
  localparam logic [8:0] SC_TWO   = 9'h01E;
  localparam logic [8:0] SC_FIVE  = 9'h02E;
  localparam logic [8:0] SC_SIX   = 9'h036;
  localparam logic [8:0] SC_S     = 9'h01B;

  localparam int NUM_KEYS = 13;
  localparam logic [3:0] KEY_UP    = 4'd0;
  localparam logic [3:0] KEY_DOWN  = 4'd1;
  localparam logic [3:0] KEY_LEFT  = 4'd2;
  localparam logic [3:0] KEY_RIGHT = 4'd3;
  localparam logic [3:0] KEY_FIRE  = 4'd4;
  localparam logic [3:0] KEY_BOMB  = 4'd5;
  localparam logic [3:0] KEY_F1    = 4'd6;
  localparam logic [3:0] KEY_ONE   = 4'd7;
  localparam logic [3:0] KEY_F2    = 4'd8;
  localparam logic [3:0] KEY_TWO   = 4'd9;
  localparam logic [3:0] KEY_FIVE  = 4'd10;
  localparam logic [3:0] KEY_SIX   = 4'd11;
  localparam logic [3:0] KEY_S     = 4'd12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } coin_state_t;

endpackage

// File: rtl/xevious_input_ctrl_if.sv
// Bundle between hps_io side (master) and the input conditioning block (slave).
interface xevious_input_ctrl_if;

  logic [10:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic        no_rotate;
  logic        vblank;

  logic up, down, left, right;
  logic fire, bomb, bomb_2;
  logic start1, start2;
  logic coin;

  modport master (
    output ps2_key, joystick_0, joystick_1, no_rotate, vblank,
    input  up, down, left, right, fire, bomb, bomb_2, start1, start2, coin
  );

  modport slave (
    input  ps2_key, joystick_0, joystick_1, no_rotate, vblank,
    output up, down, left, right, fire, bomb, bomb_2, start1, start2, coin
  );

endinterface

// File: rtl/xevious_coin_pulser.sv
// Shapes coin requests into frame-timed pulses with an enforced low gap;
// one further request may be queued while a pulse or gap is in progress.
//   state | meaning
//   IDLE  | waiting for a pending coin request
//   PULSE | coin high, counting COIN_FRAMES frame ticks
//   GAP   | coin low, counting COIN_GAP frame ticks before accepting again
module xevious_coin_pulser
  import xevious_input_pkg::*;
#(
  parameter int COIN_FRAMES = 3,
  parameter int COIN_GAP    = 2
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic src,
  input  logic tick,
  output logic coin
);

  coin_state_t state, state_nxt;
  logic [3:0]  cnt, cnt_nxt, cnt_inc;
  logic        pending, pending_nxt;
  logic        coin_nxt;
  logic        src_q, src_rise;

  assign src_rise = src & ~src_q;
  assign cnt_inc  = cnt + 4'd1;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      pending <= 1'b0;
      coin    <= 1'b0;
      src_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pending <= pending_nxt;
      coin    <= coin_nxt;
      src_q   <= src;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pending_nxt = pending | src_rise;
    coin_nxt    = coin;
    unique case (state)
      IDLE: begin
        if (pending) begin
          state_nxt   = PULSE;
          pending_nxt = src_rise;
          cnt_nxt     = 4'd0;
          coin_nxt    = 1'b1;
        end
      end
      PULSE: begin
        if (tick) begin
          if (cnt_inc == 4'(COIN_FRAMES)) begin
            state_nxt = GAP;
            cnt_nxt   = 4'd0;
            coin_nxt  = 1'b0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      GAP: begin
        if (COIN_GAP == 0) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else if (tick) begin
          if (cnt_inc == 4'(COIN_GAP)) begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
        coin_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/xevious_input_ctrl.sv
// Input conditioning between hps_io and the xevious core: PS/2 held-key decode,
// joystick merge, rotation remap, frame tick and coin shaping.
// Optional autofire is built when XEVIOUS_AUTOFIRE_EN is defined.
module xevious_input_ctrl
  import xevious_input_pkg::*;
#(
  parameter int COIN_FRAMES = 3,
  parameter int COIN_GAP    = 2,
  parameter int AF_PERIOD   = 4
) (
  input logic                 clk_sys,
  input logic                 reset,
  xevious_input_ctrl_if.slave bus
);

  logic [NUM_KEYS-1:0] keys;
  logic                toggle_q;
  logic [3:0]          key_sel;
  logic                key_hit;
  logic [8:0]          code;
  logic [15:0]         joy;
  logic                vblank_q, tick;

  logic src_up, src_down, src_left, src_right;
  logic fire_held, fire_nxt, coin_src;
  logic up_q, down_q, left_q, right_q, fire_q, bomb_q, bomb_2_q, start1_q, start2_q;
  logic unused_joy;

  assign code       = bus.ps2_key[8:0];
  assign joy        = bus.joystick_0 | bus.joystick_1;
  assign unused_joy = ^joy[15:9];
  assign tick       = bus.vblank & ~vblank_q;

  always_comb begin
    key_hit = 1'b1;
    key_sel = KEY_UP;
    case (code[7:0])
      SC_UP:    key_sel = KEY_UP;
      SC_DOWN:  key_sel = KEY_DOWN;
      SC_LEFT:  key_sel = KEY_LEFT;
      SC_RIGHT: key_sel = KEY_RIGHT;
      SC_BOMB:  key_sel = KEY_BOMB;
      default: begin
        case (code)
          SC_FIRE: key_sel = KEY_FIRE;
          SC_F1:   key_sel = KEY_F1;
          SC_ONE:  key_sel = KEY_ONE;
          SC_F2:   key_sel = KEY_F2;
          SC_TWO:  key_sel = KEY_TWO;
          SC_FIVE: key_sel = KEY_FIVE;
          SC_SIX:  key_sel = KEY_SIX;
          SC_S:    key_sel = KEY_S;
          default: key_hit = 1'b0;
        endcase
      end
    endcase
  end

  assign src_up    = keys[KEY_UP]    | joy[JOY_U];
  assign src_down  = keys[KEY_DOWN]  | joy[JOY_D];
  assign src_left  = keys[KEY_LEFT]  | joy[JOY_L];
  assign src_right = keys[KEY_RIGHT] | joy[JOY_R];
  assign fire_held = keys[KEY_FIRE]  | joy[JOY_FIRE];
  assign coin_src  = keys[KEY_FIVE]  | keys[KEY_SIX] | joy[JOY_COIN];

`ifdef XEVIOUS_AUTOFIRE_EN
  logic       fire_held_q, af_phase;
  logic [3:0] af_cnt;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      fire_held_q <= 1'b0;
      af_phase    <= 1'b0;
      af_cnt      <= 4'd0;
    end else begin
      fire_held_q <= fire_held;
      if (!fire_held || !fire_held_q) begin
        af_phase <= 1'b1;
        af_cnt   <= 4'd0;
      end else if (tick) begin
        if (af_cnt == 4'(AF_PERIOD - 1)) begin
          af_phase <= ~af_phase;
          af_cnt   <= 4'd0;
        end else begin
          af_cnt <= af_cnt + 4'd1;
        end
      end
    end
  end

  // the press cycle fires regardless of phase so the first shot is immediate
  assign fire_nxt = fire_held & (~fire_held_q | af_phase);
`else
  logic unused_af;
  assign unused_af = ^4'(AF_PERIOD);
  assign fire_nxt  = fire_held;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      keys     <= '0;
      toggle_q <= 1'b0;
      vblank_q <= 1'b0;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      fire_q   <= 1'b0;
      bomb_q   <= 1'b0;
      bomb_2_q <= 1'b0;
      start1_q <= 1'b0;
      start2_q <= 1'b0;
    end else begin
      toggle_q <= bus.ps2_key[10];
      vblank_q <= bus.vblank;
      if ((bus.ps2_key[10] != toggle_q) && key_hit)
        keys[key_sel] <= bus.ps2_key[9];
      // horizontal cabinet: the panel is turned a quarter, directions rotate with it
      up_q     <= bus.no_rotate ? src_left  : src_up;
      down_q   <= bus.no_rotate ? src_right : src_down;
      left_q   <= bus.no_rotate ? src_down  : src_left;
      right_q  <= bus.no_rotate ? src_up    : src_right;
      fire_q   <= fire_nxt;
      bomb_q   <= keys[KEY_BOMB] | joy[JOY_BOMB];
      bomb_2_q <= keys[KEY_S]    | joy[JOY_BOMB];
      start1_q <= keys[KEY_F1]   | keys[KEY_ONE] | joy[JOY_ST1];
      start2_q <= keys[KEY_F2]   | keys[KEY_TWO] | joy[JOY_ST2];
    end
  end

  xevious_coin_pulser #(
    .COIN_FRAMES (COIN_FRAMES),
    .COIN_GAP    (COIN_GAP)
  ) u_coin (
    .clk_sys (clk_sys),
    .reset   (reset),
    .src     (coin_src),
    .tick    (tick),
    .coin    (bus.coin)
  );

  assign bus.up     = up_q;
  assign bus.down   = down_q;
  assign bus.left   = left_q;
  assign bus.right  = right_q;
  assign bus.fire   = fire_q;
  assign bus.bomb   = bomb_q;
  assign bus.bomb_2 = bomb_2_q;
  assign bus.start1 = start1_q;
  assign bus.start2 = start2_q;

endmodule

// File: tb/tb_xevious_input_ctrl.sv
// Directed bench for xevious_input_ctrl: expected output vectors are queued when
// stimulus is applied and popped when the registered outputs are sampled.
module tb_xevious_input_ctrl;

  localparam logic [9:0] O_UP    = 10'h200;
  localparam logic [9:0] O_DOWN  = 10'h100;
  localparam logic [9:0] O_LEFT  = 10'h080;
  localparam logic [9:0] O_RIGHT = 10'h040;
  localparam logic [9:0] O_FIRE  = 10'h020;
  localparam logic [9:0] O_BOMB  = 10'h010;
  localparam logic [9:0] O_BOMB2 = 10'h008;
  localparam logic [9:0] O_ST1   = 10'h004;
  localparam logic [9:0] O_ST2   = 10'h002;
  localparam logic [9:0] O_COIN  = 10'h001;

  typedef struct {
    string      tag;
    logic [9:0] exp;
  } exp_t;

  exp_t sb[$];

  logic clk = 1'b0;
  logic reset;
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;

  xevious_input_ctrl_if bus ();

  xevious_input_ctrl dut (
    .clk_sys (clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [9:0] obs;
  assign obs = {bus.up, bus.down, bus.left, bus.right, bus.fire,
                bus.bomb, bus.bomb_2, bus.start1, bus.start2, bus.coin};

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input string tag, input logic [9:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic check();
    exp_t x;
    total++;
    if (sb.size() == 0) begin
      failed++;
      $error("FAIL sb_empty: observed %b, no expected entry queued", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) passed++;
      else begin
        failed++;
        $error("FAIL %s: observed %b expected %b", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic key(input logic pressed, input logic [8:0] code);
    bus.ps2_key = {~bus.ps2_key[10], pressed, code};
  endtask

  task automatic frame();
    bus.vblank = 1'b1;
    step(1);
    bus.vblank = 1'b0;
    step(1);
  endtask

  task automatic coin_edge();
    bus.joystick_0 = 16'h0100;
    step(1);
    bus.joystick_0 = 16'h0000;
    step(1);
  endtask

  initial begin
    reset          = 1'b1;
    bus.ps2_key    = '0;
    bus.joystick_0 = '0;
    bus.joystick_1 = '0;
    bus.no_rotate  = 1'b0;
    bus.vblank     = 1'b0;
    step(3);
    push("reset_state", 10'h000); check();
    reset = 1'b0;
    step(1);

    // PS/2 keys: two-edge latency, release, unknown code, extended bit ignored
    key(1'b1, 9'h029);
    push("fire_key_edge1", 10'h000); step(1); check();
    push("fire_key_edge2", O_FIRE);  step(1); check();
    key(1'b0, 9'h029);
    push("fire_key_release", 10'h000); step(2); check();
    key(1'b1, 9'h01C);
    push("unknown_code", 10'h000); step(2); check();
    key(1'b1, 9'h175);
    push("up_ext_key", O_UP); step(2); check();
    key(1'b0, 9'h075);
    push("up_plain_release", 10'h000); step(2); check();
    key(1'b1, 9'h114); step(2);
    key(1'b1, 9'h01B);
    push("bomb_and_s", O_BOMB | O_BOMB2); step(2); check();
    key(1'b0, 9'h014); step(2);
    key(1'b0, 9'h01B); step(2);
    key(1'b1, 9'h005); step(2);
    key(1'b1, 9'h01E);
    push("start_keys", O_ST1 | O_ST2); step(2); check();
    key(1'b0, 9'h005); step(2);
    key(1'b0, 9'h01E);
    push("start_release", 10'h000); step(2); check();
    key(1'b1, 9'h02E);
    push("coin_key_pending", 10'h000); step(2); check();
    push("coin_key_pulse", O_COIN);    step(1); check();
    key(1'b0, 9'h02E);
    repeat (5) frame();
    push("coin_key_done", 10'h000); check();

    // joystick merge and rotation, one-edge latency
    bus.joystick_0 = 16'h0008;
    push("joy_up_direct", O_UP); step(1); check();
    bus.no_rotate = 1'b1;
    push("joy_up_rotated", O_RIGHT); step(1); check();
    bus.joystick_0 = 16'h0002;
    push("joy_left_rotated", O_UP); step(1); check();
    bus.joystick_0 = 16'h0000;
    bus.joystick_1 = 16'h0005;
    push("joy1_r_d_rotated", O_DOWN | O_LEFT); step(1); check();
    bus.no_rotate = 1'b0;
    push("joy1_r_d_direct", O_RIGHT | O_DOWN); step(1); check();
    bus.joystick_1 = 16'h0000;
    bus.joystick_0 = 16'h00E0;
    push("joy_bomb_starts", O_BOMB | O_BOMB2 | O_ST1 | O_ST2); step(1); check();
    bus.joystick_0 = 16'h0000;
    step(1);

    // single coin: three frames high, then nothing more
    coin_edge();
    push("coin1_start", O_COIN); check();
    for (int k = 1; k <= 10; k++) begin
      frame();
      push($sformatf("coin1_frame%0d", k), (k < 3) ? O_COIN : 10'h000);
      check();
    end

    // extra edges during a pulse queue exactly one more pulse after the gap
    coin_edge();
    push("coin2_start", O_COIN); check();
    repeat (3) coin_edge();
    push("coin2_after_edges", O_COIN); check();
    for (int k = 1; k <= 12; k++) begin
      frame();
      push($sformatf("coin2_frame%0d", k),
           ((k <= 2) || (k >= 5 && k <= 7)) ? O_COIN : 10'h000);
      check();
    end

    // reset mid-pulse with a request queued
    coin_edge();
    frame();
    coin_edge();
    push("coin3_pulse", O_COIN); check();
    reset = 1'b1;
    push("coin3_reset_drop", 10'h000); step(1); check();
    step(1);
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      frame();
      push($sformatf("coin3_post_reset%0d", k), 10'h000);
      check();
    end

    // fire held across 16 frame ticks
    bus.joystick_0 = 16'h0010;
    step(1);
    for (int i = 0; i < 16; i++) begin
`ifdef XEVIOUS_AUTOFIRE_EN
      push($sformatf("fire_hold_tick%0d", i), (((i / 4) % 2) == 0) ? O_FIRE : 10'h000);
`else
      push($sformatf("fire_hold_tick%0d", i), O_FIRE);
`endif
      check();
      frame();
    end
    bus.joystick_0 = 16'h0000;
    push("fire_hold_release", 10'h000); step(1); check();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
